// File: rtl/mem_bank_router_if.sv
// Master-side request/response bus of the bank router.
// The master drives requests; the router returns read responses.
interface mem_bank_router_if #(
    parameter int NUM_BANKS = 3,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [BANK_W-1:0] req_bank;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_wren;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_bank, req_addr, req_wdata, req_wren,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_bank, req_addr, req_wdata, req_wren,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_bank_router.sv
// Routes single-word requests to one of NUM_BANKS single-port RAMs and
// can zero every bank with a full-address sweep.
module mem_bank_router #(
    parameter int NUM_BANKS  = 3,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    mem_bank_router_if.slave            bus,
    input  logic                        clear_start,
    output logic                        clear_busy,
    output logic                        clear_done,
    output logic                        err_sticky,
    output logic [NUM_BANKS*ADDR_W-1:0] bank_addr,
    output logic [NUM_BANKS*DATA_W-1:0] bank_data,
    output logic [NUM_BANKS-1:0]        bank_wren,
    input  logic [NUM_BANKS*DATA_W-1:0] bank_q
);
    localparam int                BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   LAST   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [BANK_W:0]   NB     = (BANK_W+1)'(NUM_BANKS);

    typedef enum logic [0:0] {IDLE, CLEAR} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   cnt_reg, cnt_next;
    logic              clear_done_reg, clear_done_next;
    logic              err_sticky_reg;
    logic              accept;
    logic              bank_ok;

    logic              pipe_valid_reg [0:RD_LATENCY];
    logic              pipe_err_reg   [0:RD_LATENCY];
    logic [BANK_W-1:0] pipe_bank_reg  [0:RD_LATENCY];
    logic [DATA_W-1:0] rsp_rdata_mux;

    assign bus.req_ready = (state_reg == IDLE);
    assign accept        = bus.req_valid && bus.req_ready;
    assign bank_ok       = ({1'b0, bus.req_bank} < NB);
    assign clear_busy    = (state_reg == CLEAR);
    assign clear_done    = clear_done_reg;
    assign err_sticky    = err_sticky_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            clear_done_reg <= 1'b0;
            err_sticky_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            clear_done_reg <= clear_done_next;
            if (accept && !bank_ok)
                err_sticky_reg <= 1'b1;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        clear_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (clear_start)
                    state_next = CLEAR;
            end
            CLEAR: begin
                cnt_next = cnt_reg + 1'b1;
                // Leave on the last address so the counter never wraps back to 0.
                if (cnt_reg == LAST) begin
                    state_next      = IDLE;
                    cnt_next        = '0;
                    clear_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered per-bank ports; the sweep owns every bank while in CLEAR.
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [ADDR_W-1:0] addr_reg;
        logic [DATA_W-1:0] data_reg;
        logic              wren_reg;
        logic              hit;

        assign hit = accept && bank_ok && (bus.req_bank == BANK_W'(gi));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                addr_reg <= '0;
                data_reg <= '0;
                wren_reg <= 1'b0;
            end else if (state_reg == CLEAR) begin
                addr_reg <= cnt_reg[ADDR_W-1:0];
                data_reg <= '0;
                wren_reg <= 1'b1;
            end else if (hit) begin
                addr_reg <= bus.req_addr;
                wren_reg <= bus.req_wren;
                if (bus.req_wren)
                    data_reg <= bus.req_wdata;
            end else begin
                wren_reg <= 1'b0;
            end
        end

        assign bank_addr[gi*ADDR_W +: ADDR_W] = addr_reg;
        assign bank_data[gi*DATA_W +: DATA_W] = data_reg;
        assign bank_wren[gi]                  = wren_reg;
    end

    // Stage 0 lines up with the bank address cycle; the last stage with bank_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                pipe_valid_reg[i] <= 1'b0;
                pipe_err_reg[i]   <= 1'b0;
                pipe_bank_reg[i]  <= '0;
            end
        end else begin
            pipe_valid_reg[0] <= accept && !bus.req_wren;
            pipe_err_reg[0]   <= !bank_ok;
            pipe_bank_reg[0]  <= bus.req_bank;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                pipe_valid_reg[i] <= pipe_valid_reg[i-1];
                pipe_err_reg[i]   <= pipe_err_reg[i-1];
                pipe_bank_reg[i]  <= pipe_bank_reg[i-1];
            end
        end
    end

    always_comb begin
        rsp_rdata_mux = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (pipe_valid_reg[RD_LATENCY] && !pipe_err_reg[RD_LATENCY] &&
                pipe_bank_reg[RD_LATENCY] == BANK_W'(k))
                rsp_rdata_mux = bank_q[k*DATA_W +: DATA_W];
        end
    end

    assign bus.rsp_valid = pipe_valid_reg[RD_LATENCY];
    assign bus.rsp_err   = pipe_valid_reg[RD_LATENCY] && pipe_err_reg[RD_LATENCY];
    assign bus.rsp_rdata = rsp_rdata_mux;
endmodule

// File: tb/tb_mem_bank_router.sv
// Directed bench for mem_bank_router: three modelled RAM banks, a vector
// table of single transactions, and hand-written burst/clear/reset sequences.
module tb_mem_bank_router;
    localparam int NB = 3;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk;
    logic          reset;
    logic          clear_start;
    logic          clear_busy;
    logic          clear_done;
    logic          err_sticky;
    logic [NB*AW-1:0] bank_addr;
    logic [NB*DW-1:0] bank_data;
    logic [NB-1:0]    bank_wren;
    logic [NB*DW-1:0] bank_q;

    mem_bank_router_if #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bank_router #(.NUM_BANKS(NB), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
        .err_sticky(err_sticky), .bank_addr(bank_addr), .bank_data(bank_data),
        .bank_wren(bank_wren), .bank_q(bank_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM models with one cycle of registered read
    logic [DW-1:0] mem [NB][16];
    logic [DW-1:0] q   [NB];
    initial begin
        for (int k = 0; k < NB; k++) begin
            q[k] = '0;
            for (int a = 0; a < 16; a++) mem[k][a] = '0;
        end
    end
    always @(posedge clk) begin
        for (int k = 0; k < NB; k++) begin
            if (bank_wren[k]) mem[k][bank_addr[k*AW +: AW]] <= bank_data[k*DW +: DW];
            q[k] <= mem[k][bank_addr[k*AW +: AW]];
        end
    end
    always_comb bank_q = {q[2], q[1], q[0]};

    typedef struct { int cyc; logic [DW-1:0] d; logic e; } rsp_t;
    typedef struct { int cyc; int bank; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];

    always @(negedge clk) begin
        if (bus.rsp_valid) rsp_q.push_back('{cyc, bus.rsp_rdata, bus.rsp_err});
        for (int k = 0; k < NB; k++)
            if (bank_wren[k]) wr_q.push_back('{cyc, k, bank_addr[k*AW +: AW], bank_data[k*DW +: DW]});
    end

    int checks = 0;
    int errors = 0;
    logic sticky_model = 1'b0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] b, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic clr, output int acc);
        int n = 0;
        while (!bus.req_ready && n < 64) begin @(posedge clk); #1; n++; end
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout got 0 expected 1");
        end
        bus.req_valid = 1'b1; bus.req_wren = wr; bus.req_bank = b;
        bus.req_addr = a; bus.req_wdata = d; clear_start = clr;
        @(posedge clk); #1;
        acc = cyc;
        bus.req_valid = 1'b0; bus.req_wren = 1'b0; clear_start = 1'b0;
    endtask

    typedef struct {
        logic wr; logic [1:0] bank; logic [AW-1:0] addr; logic [DW-1:0] wdata;
        logic exp_rsp; logic [DW-1:0] exp_rdata; logic exp_err;
    } vec_t;

    task automatic run_vec(input vec_t v, input int idx);
        int acc;
        logic exp_wr;
        issue(v.wr, v.bank, v.addr, v.wdata, 1'b0, acc);
        if (v.bank == 2'd3) sticky_model = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rsp_count", idx, rsp_q.size(), v.exp_rsp ? 1 : 0);
        if (v.exp_rsp && rsp_q.size() > 0) begin
            chk("rsp_cycle", idx, rsp_q[0].cyc, acc + 1);
            chk("rsp_rdata", idx, rsp_q[0].d, v.exp_rdata);
            chk("rsp_err", idx, rsp_q[0].e, v.exp_err);
        end
        exp_wr = v.wr && (v.bank != 2'd3);
        chk("wren_count", idx, wr_q.size(), exp_wr ? 1 : 0);
        if (exp_wr && wr_q.size() > 0) begin
            chk("wren_cycle", idx, wr_q[0].cyc, acc);
            chk("wren_bank", idx, wr_q[0].bank, v.bank);
            chk("wren_addr", idx, wr_q[0].a, v.addr);
            chk("wren_data", idx, wr_q[0].d, v.wdata);
        end
        chk("err_sticky", idx, err_sticky, sticky_model);
        $display("vec %0d wr=%0d bank=%0d addr=%h wdata=%h rsp=%0d", idx, v.wr, v.bank, v.addr, v.wdata, rsp_q.size());
        rsp_q.delete(); wr_q.delete();
    endtask

    task automatic chk_reset_outputs(input int idx);
        chk("rst_ready", idx, bus.req_ready, 1);
        chk("rst_rsp_valid", idx, bus.rsp_valid, 0);
        chk("rst_rsp_rdata", idx, bus.rsp_rdata, 0);
        chk("rst_rsp_err", idx, bus.rsp_err, 0);
        chk("rst_err_sticky", idx, err_sticky, 0);
        chk("rst_clear_busy", idx, clear_busy, 0);
        chk("rst_clear_done", idx, clear_done, 0);
        chk("rst_bank_wren", idx, bank_wren, 0);
        chk("rst_bank_addr", idx, bank_addr, 0);
        chk("rst_bank_data", idx, bank_data, 0);
    endtask

    vec_t tbl[14];
    vec_t rb[2];

    initial begin
        int acc, acc0, busy_n, bad, done_n, done_cyc, first_busy, seq_bad;
        logic [1:0]    b2b_bank [4];
        logic [AW-1:0] b2b_addr [4];
        logic [DW-1:0] b2b_data [4];

        tbl[0]  = '{1'b1, 2'd1, 4'h5, 8'hA7, 1'b0, 8'h00, 1'b0};
        tbl[1]  = '{1'b0, 2'd1, 4'h5, 8'h00, 1'b1, 8'hA7, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 4'h3, 8'h11, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{1'b1, 2'd2, 4'h3, 8'h22, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 2'd0, 4'h3, 8'h00, 1'b1, 8'h11, 1'b0};
        tbl[5]  = '{1'b0, 2'd2, 4'h3, 8'h00, 1'b1, 8'h22, 1'b0};
        tbl[6]  = '{1'b0, 2'd1, 4'h3, 8'h00, 1'b1, 8'h00, 1'b0};
        tbl[7]  = '{1'b1, 2'd3, 4'h5, 8'hFF, 1'b0, 8'h00, 1'b0};
        tbl[8]  = '{1'b0, 2'd1, 4'h5, 8'h00, 1'b1, 8'hA7, 1'b0};
        tbl[9]  = '{1'b0, 2'd3, 4'h5, 8'h00, 1'b1, 8'h00, 1'b1};
        tbl[10] = '{1'b1, 2'd0, 4'hF, 8'h5A, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 4'hF, 8'h00, 1'b1, 8'h5A, 1'b0};
        tbl[12] = '{1'b1, 2'd1, 4'h5, 8'h3C, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 2'd1, 4'h5, 8'h00, 1'b1, 8'h3C, 1'b0};
        rb[0]   = '{1'b0, 2'd1, 4'h5, 8'h00, 1'b1, 8'h00, 1'b0};
        rb[1]   = '{1'b0, 2'd0, 4'hF, 8'h00, 1'b1, 8'h00, 1'b0};
        b2b_bank = '{2'd0, 2'd1, 2'd2, 2'd0};
        b2b_addr = '{4'h1, 4'h2, 4'h3, 4'h4};
        b2b_data = '{8'h31, 8'h42, 8'h53, 8'h64};

        bus.req_valid = 1'b0; bus.req_wren = 1'b0; bus.req_bank = '0;
        bus.req_addr = '0; bus.req_wdata = '0; clear_start = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs(0);
        $display("reset released, ready=%0d", bus.req_ready);

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        // Four back-to-back reads after preloading distinct data
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, b2b_bank[i], b2b_addr[i], b2b_data[i], 1'b0, acc);
            $display("preload bank=%0d addr=%h data=%h", b2b_bank[i], b2b_addr[i], b2b_data[i]);
        end
        repeat (2) @(posedge clk); #1;
        rsp_q.delete(); wr_q.delete();
        for (int i = 0; i < 4; i++) begin
            bus.req_valid = 1'b1; bus.req_wren = 1'b0;
            bus.req_bank = b2b_bank[i]; bus.req_addr = b2b_addr[i];
            @(posedge clk); #1;
            if (i == 0) acc0 = cyc;
        end
        bus.req_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("b2b_count", 0, rsp_q.size(), 4);
        for (int i = 0; i < 4 && i < rsp_q.size(); i++) begin
            chk("b2b_cycle", i, rsp_q[i].cyc, acc0 + 1 + i);
            chk("b2b_rdata", i, rsp_q[i].d, b2b_data[i]);
            chk("b2b_err", i, rsp_q[i].e, 0);
            $display("b2b rsp %0d data=%h", i, rsp_q[i].d);
        end
        chk("b2b_wren", 0, wr_q.size(), 0);
        rsp_q.delete(); wr_q.delete();

        // Clear sweep started together with a read of bank1 addr5
        issue(1'b0, 2'd1, 4'h5, 8'h00, 1'b1, acc);
        busy_n = 0; bad = 0; done_n = 0; done_cyc = -1; first_busy = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (clear_busy) begin
                busy_n++;
                if (first_busy < 0) first_busy = cyc;
                if (bus.req_ready) bad++;
            end
            if (clear_done) begin done_n++; done_cyc = cyc; end
        end
        chk("clr_busy_cycles", 0, busy_n, 16);
        chk("clr_busy_start", 0, first_busy, acc);
        chk("clr_ready_low", 0, bad, 0);
        chk("clr_done_pulses", 0, done_n, 1);
        chk("clr_done_cycle", 0, done_cyc, acc + 16);
        chk("clr_wren_count", 0, wr_q.size(), 48);
        seq_bad = 0;
        for (int j = 0; j < wr_q.size(); j++)
            if (wr_q[j].cyc != acc + 1 + j/3 || wr_q[j].bank != j%3 ||
                wr_q[j].a != AW'(j/3) || wr_q[j].d != '0) seq_bad++;
        chk("clr_wren_seq", 0, seq_bad, 0);
        chk("clr_rsp_count", 0, rsp_q.size(), 1);
        if (rsp_q.size() > 0) begin
            chk("clr_rsp_cycle", 0, rsp_q[0].cyc, acc + 1);
            chk("clr_rsp_rdata", 0, rsp_q[0].d, 8'h3C);
        end
        $display("clear busy=%0d done=%0d writes=%0d", busy_n, done_n, wr_q.size());
        rsp_q.delete(); wr_q.delete();
        for (int i = 0; i < 2; i++) run_vec(rb[i], 100 + i);

        // Reset mid-sweep with two reads in flight
        issue(1'b0, 2'd0, 4'h1, 8'h00, 1'b0, acc);
        issue(1'b0, 2'd3, 4'h2, 8'h00, 1'b1, acc);
        chk("pre_rst_busy", 0, clear_busy, 1);
        reset = 1'b1;
        rsp_q.delete(); wr_q.delete();
        sticky_model = 1'b0;
        @(negedge clk);
        chk_reset_outputs(1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk_reset_outputs(2);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("post_rst_rsp", 0, rsp_q.size(), 0);
        chk("post_rst_wren", 0, wr_q.size(), 0);
        chk("post_rst_ready", 0, bus.req_ready, 1);
        $display("reset mid-sweep, rsp after release=%0d", rsp_q.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
